// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver. It synchronises the data line and times each
// high pulse. Pulses decode as 0/1 bits and are packed MSB-first into 24-bit
// words. Each word is reported with its index within the current frame.
module ws2812_rx #(
    parameter int NUM_LEDS = 8,
    parameter int T_MIN    = 2,
    parameter int T_THRESH = 7,
    parameter int T_MAX    = 14,
    parameter int T_RESET  = 600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        valid,
    output logic        frame_done,
    output logic        bit_error,
    output logic        busy
);

    localparam logic [9:0] T_MIN_C    = 10'(T_MIN);
    localparam logic [9:0] T_THRESH_C = 10'(T_THRESH);
    localparam logic [9:0] T_MAX_C    = 10'(T_MAX);
    localparam logic [9:0] T_RESET_C  = 10'(T_RESET);
    localparam logic [8:0] NUM_LEDS_C = 9'(NUM_LEDS);

    typedef enum logic {SYNC, RX} state_t;

    logic        din_meta_reg, din_s_reg, din_q_reg;
    logic [9:0]  high_cnt_reg, low_cnt_reg;
    state_t      state_reg, state_next;
    logic [23:0] shift_reg, shift_next;
    logic [4:0]  bit_cnt_reg, bit_cnt_next;
    logic [8:0]  led_idx_reg, led_idx_next;
    logic        any_bit_reg, any_bit_next;
    logic [23:0] rgb_data_reg, rgb_data_next;
    logic [7:0]  led_num_reg, led_num_next;
    logic        valid_reg, valid_next;
    logic        frame_done_reg, frame_done_next;
    logic        bit_error_reg, bit_error_next;

    logic fall;
    logic frame_end;
    logic bit_val;

    assign fall      = din_q_reg & ~din_s_reg;
    assign frame_end = (low_cnt_reg == T_RESET_C);
    assign bit_val   = (high_cnt_reg > T_THRESH_C);

    // Two-flop synchroniser for the asynchronous line, plus a delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            din_meta_reg <= 1'b0;
            din_s_reg    <= 1'b0;
            din_q_reg    <= 1'b0;
        end else begin
            din_meta_reg <= din;
            din_s_reg    <= din_meta_reg;
            din_q_reg    <= din_s_reg;
        end
    end

    // Saturating high/low duration counters; high count survives until its falling edge is decoded
    always_ff @(posedge clk) begin
        if (reset) begin
            high_cnt_reg <= '0;
            low_cnt_reg  <= '0;
        end else begin
            if (din_s_reg) begin
                if (high_cnt_reg != 10'h3FF)
                    high_cnt_reg <= high_cnt_reg + 10'd1;
                low_cnt_reg <= '0;
            end else begin
                if (fall)
                    high_cnt_reg <= '0;
                if (low_cnt_reg != 10'h3FF)
                    low_cnt_reg <= low_cnt_reg + 10'd1;
            end
        end
    end

    // State, word assembly and registered output pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= SYNC;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            led_idx_reg    <= '0;
            any_bit_reg    <= 1'b0;
            rgb_data_reg   <= '0;
            led_num_reg    <= '0;
            valid_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
            bit_error_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            led_idx_reg    <= led_idx_next;
            any_bit_reg    <= any_bit_next;
            rgb_data_reg   <= rgb_data_next;
            led_num_reg    <= led_num_next;
            valid_reg      <= valid_next;
            frame_done_reg <= frame_done_next;
            bit_error_reg  <= bit_error_next;
        end
    end

    // Decode each falling edge by its measured high time, and handle end-of-frame gaps
    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        led_idx_next    = led_idx_reg;
        any_bit_next    = any_bit_reg;
        rgb_data_next   = rgb_data_reg;
        led_num_next    = led_num_reg;
        valid_next      = 1'b0;
        frame_done_next = 1'b0;
        bit_error_next  = 1'b0;

        case (state_reg)
            SYNC: begin
                if (frame_end) begin
                    state_next   = RX;
                    shift_next   = '0;
                    bit_cnt_next = '0;
                    led_idx_next = '0;
                    any_bit_next = 1'b0;
                end
            end
            RX: begin
                if (fall) begin
                    if (high_cnt_reg < T_MIN_C) begin
                        bit_error_next = 1'b1;
                    end else if (high_cnt_reg <= T_MAX_C) begin
                        shift_next   = {shift_reg[22:0], bit_val};
                        any_bit_next = 1'b1;
                        if (bit_cnt_reg == 5'd23) begin
                            bit_cnt_next = '0;
                            // Words beyond the chain length are dropped without comment
                            if (led_idx_reg < NUM_LEDS_C) begin
                                rgb_data_next = shift_next;
                                led_num_next  = led_idx_reg[7:0];
                                valid_next    = 1'b1;
                                led_idx_next  = led_idx_reg + 9'd1;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 5'd1;
                        end
                    end else begin
                        // Over-long pulse: we have lost bit alignment, resynchronise on the next gap
                        bit_error_next = 1'b1;
                        bit_cnt_next   = '0;
                        any_bit_next   = 1'b0;
                        state_next     = SYNC;
                    end
                end else if (frame_end) begin
                    frame_done_next = any_bit_reg;
                    bit_error_next  = (bit_cnt_reg != 5'd0);
                    bit_cnt_next    = '0;
                    led_idx_next    = '0;
                    any_bit_next    = 1'b0;
                end
            end
            default: state_next = SYNC;
        endcase
    end

    assign rgb_data   = rgb_data_reg;
    assign led_num    = led_num_reg;
    assign valid      = valid_reg;
    assign frame_done = frame_done_reg;
    assign bit_error  = bit_error_reg;
    assign busy       = (state_reg == RX) && any_bit_reg;

endmodule

// File: tb/tb_ws2812_rx.sv
// Randomised bench for ws2812_rx. A pulse-level model predicts decoded words, frame ends
// and errors into a queue; a monitor compares them against DUT output pulses.
module tb_ws2812_rx;

    localparam int NUM_LEDS = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        din = 1'b0;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        valid, frame_done, bit_error, busy;

    always #5 clk = ~clk;

    ws2812_rx #(.NUM_LEDS(NUM_LEDS), .T_MIN(2), .T_THRESH(7), .T_MAX(14), .T_RESET(600)) dut (
        .clk(clk), .reset(reset), .din(din), .rgb_data(rgb_data), .led_num(led_num),
        .valid(valid), .frame_done(frame_done), .bit_error(bit_error), .busy(busy)
    );

    // kind: 0 = word, 1 = frame end (err = partial word), 2 = error only
    typedef struct {
        int          kind;
        logic [23:0] data;
        int          idx;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   end_req = 0;
    bit   end_done = 0;

    // Reference model state, expressed at the level of whole pulses and gap lengths
    bit          m_synced = 0;
    logic [23:0] m_word = '0;
    int          m_cnt = 0;
    int          m_led = 0;
    bit          m_any = 0;
    int          m_low = 0;

    function automatic void push(int k, logic [23:0] d, int i, bit e);
        exp_t x;
        x.kind = k; x.data = d; x.idx = i; x.err = e;
        exp_q.push_back(x);
    endfunction

    function automatic void model_high(int h);
        logic b;
        m_low = 0;
        if (!m_synced) return;
        if (h < 2) begin
            push(2, 24'h0, 0, 1'b1);
        end else if (h <= 14) begin
            b = (h > 7);
            m_word = {m_word[22:0], b};
            m_cnt++;
            m_any = 1;
            if (m_cnt == 24) begin
                if (m_led < NUM_LEDS) push(0, m_word, m_led, 1'b0);
                m_led++;
                m_cnt = 0;
            end
        end else begin
            push(2, 24'h0, 0, 1'b1);
            m_synced = 0;
            m_cnt = 0;
            m_any = 0;
        end
    endfunction

    function automatic void model_low(int n);
        int prev;
        prev = m_low;
        m_low = (prev + n > 100000) ? 100000 : prev + n;
        if (prev < 600 && prev + n >= 600) begin
            if (!m_synced) m_synced = 1;
            else if (m_any) push(1, 24'h0, 0, m_cnt != 0);
            m_cnt = 0;
            m_led = 0;
            m_any = 0;
        end
    endfunction

    task automatic drive(bit v, int n);
        repeat (n) begin
            @(negedge clk);
            din = v;
        end
    endtask

    task automatic pulse(int h, int l);
        model_high(h);
        drive(1'b1, h);
        model_low(l);
        drive(1'b0, l);
    endtask

    task automatic idle(int n);
        model_low(n);
        drive(1'b0, n);
    endtask

    task automatic send_word_std(logic [23:0] w);
        for (int i = 23; i >= 0; i--) pulse(w[i] ? 10 : 5, w[i] ? 5 : 10);
    endtask

    task automatic send_bits_rand(logic [23:0] w, int nbits, bit noisy);
        for (int i = 23; i > 23 - nbits; i--) begin
            if (noisy && $urandom_range(0, 39) == 0) pulse(1, $urandom_range(3, 6));
            if (noisy && $urandom_range(0, 99) == 0) pulse($urandom_range(15, 30), $urandom_range(3, 8));
            pulse(w[i] ? $urandom_range(8, 14) : $urandom_range(2, 7),
                  ($urandom_range(0, 149) == 0) ? 599 : $urandom_range(3, 20));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_synced = 0; m_cnt = 0; m_led = 0; m_any = 0; m_low = 0;
    endtask

    // Monitor: checks reset values, then matches every output pulse against the model queue
    always @(posedge clk) begin
        exp_t e;
        int   gk;
        #1;
        if (reset) begin
            n_cmp++;
            if (valid || frame_done || bit_error || busy || rgb_data != 24'h0 || led_num != 8'h0) begin
                n_bad++;
                $display("FAIL reset_outputs: got v=%0b fd=%0b err=%0b busy=%0b data=%h led=%0d, expected all 0",
                         valid, frame_done, bit_error, busy, rgb_data, led_num);
            end
        end else begin
            if (valid || frame_done || bit_error) begin
                n_cmp++;
                if (valid && !frame_done && !bit_error) gk = 0;
                else if (frame_done && !valid) gk = 1;
                else if (bit_error && !valid) gk = 2;
                else gk = 3;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got v=%0b fd=%0b err=%0b data=%h led=%0d, expected none",
                             valid, frame_done, bit_error, rgb_data, led_num);
                end else begin
                    e = exp_q.pop_front();
                    if (gk != e.kind) begin
                        n_bad++;
                        $display("FAIL event_kind: got kind=%0d (v=%0b fd=%0b err=%0b), expected kind=%0d",
                                 gk, valid, frame_done, bit_error, e.kind);
                    end else if (gk == 0 && (rgb_data != e.data || led_num != 8'(e.idx) || !busy)) begin
                        n_bad++;
                        $display("FAIL word: got data=%h led=%0d busy=%0b, expected data=%h led=%0d busy=1",
                                 rgb_data, led_num, busy, e.data, e.idx);
                    end else if (gk == 1 && (bit_error != e.err || busy)) begin
                        n_bad++;
                        $display("FAIL frame_end: got err=%0b busy=%0b, expected err=%0b busy=0",
                                 bit_error, busy, e.err);
                    end else begin
                        $display("ok kind=%0d data=%h led=%0d err=%0b", gk, rgb_data, led_num, bit_error);
                    end
                end
            end
            if (end_req && !end_done) begin
                end_done = 1;
                n_cmp++;
                if (exp_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL pending_expectations: got %0d still queued, expected 0", exp_q.size());
                end
            end
        end
    end

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;

        // Basic decode after an idle gap
        idle(650);
        send_word_std(24'hA5C30F);
        idle(650);

        // Nine words: ninth dropped, one frame end
        for (int w = 1; w <= 9; w++) send_word_std(24'(w));
        idle(650);

        // Bits straight after reset are ignored until a full gap
        do_reset();
        send_word_std(24'h123456);
        idle(650);
        send_word_std(24'h654321);
        idle(650);

        // Glitch in the low phase of bit 5: error, word still decodes
        for (int i = 23; i >= 0; i--) begin
            if (i == 18) begin
                pulse(10, 3);
                pulse(1, 8);
            end else begin
                pulse(i[0] ? 10 : 5, i[0] ? 5 : 10);
            end
        end
        idle(650);

        // Over-long pulse mid-word kills the rest of the frame
        for (int i = 0; i < 8; i++) pulse(10, 5);
        pulse(20, 5);
        send_word_std(24'hFFFFFF);
        send_word_std(24'h0F0F0F);
        idle(650);
        send_word_std(24'hC0FFEE);
        idle(650);

        // Partial word at frame end, then next word restarts at index 0
        send_word_std(24'h111111);
        for (int i = 0; i < 12; i++) pulse(5, 10);
        idle(650);
        send_word_std(24'h222222);
        idle(650);

        // Reset during bit 10 of word 2
        send_word_std(24'h333333);
        for (int i = 0; i < 9; i++) pulse(10, 5);
        pulse(10, 3);
        do_reset();
        for (int i = 0; i < 14; i++) pulse(5, 10);
        idle(650);
        send_word_std(24'h444444);

        // Gap of 599 mid-word does not end the frame; exactly 600 does
        for (int i = 0; i < 12; i++) pulse(10, (i == 5) ? 599 : 5);
        for (int i = 0; i < 12; i++) pulse(5, 10);
        idle(600);
        send_word_std(24'h5A5A5A);
        idle(600);

        // Randomised frames with noise, partial words and boundary gaps
        for (int f = 0; f < 6; f++) begin
            int nw;
            nw = $urandom_range(1, 10);
            for (int w = 0; w < nw; w++) send_bits_rand(24'($urandom), 24, 1'b1);
            if ($urandom_range(0, 2) == 0) send_bits_rand(24'($urandom), $urandom_range(1, 23), 1'b0);
            idle(($urandom_range(0, 1) == 1) ? 600 : 650 + $urandom_range(0, 50));
        end

        repeat (10) @(negedge clk);
        end_req = 1;
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Decoder for the WS2812 single-wire LED protocol.
- Samples a WS2812 data line, measures each high pulse, recovers 24-bit words (MSB first), and presents each word with its position in the frame.
- Used as a loopback checker for our WS2812 driver output, and to sniff/forward a chain's data stream into on-chip logic.
- 12 MHz clk; timing parameters are in clk counts.

Parameters:
- NUM_LEDS, 8: words accepted per frame (1..256); later words in the same frame are dropped.
- T_MIN, 2: high pulses shorter than this are glitches.
- T_THRESH, 7: high time > T_THRESH decodes as 1, otherwise 0.
- T_MAX, 14: high time > T_MAX is a framing error.
- T_RESET, 600: low time that ends a frame (must be < 1024).

Ports:
- clk  in  1  system clock, 12 MHz
- reset  in  1  synchronous, active-high
- din  in  1  asynchronous WS2812 data line
- rgb_data  out  24  last decoded word; first received bit = bit 23
- led_num  out  8  index of rgb_data in frame; first word = 0
- valid  out  1  one-cycle pulse; rgb_data/led_num valid
- frame_done  out  1  one-cycle pulse at end of frame
- bit_error  out  1  one-cycle pulse on glitch, over-long pulse, or partial word at frame end
- busy  out  1  high in RX state with at least one bit received since last frame end

Behaviour:
- Clocking and reset: clk is the only clock; reset is synchronous, active-high.
- Reset values: all outputs 0, state SYNC, all counters 0. Reset dominates every other event, including mid-word.
- Synchroniser: din passes through 2 flops to give din_s. din_q is din_s delayed 1 cycle. Falling edge = din_q & ~din_s.
- high_cnt (10 bit, saturating at 1023): increments while din_s=1; cleared on the cycle after a falling edge is processed.
- low_cnt (10 bit, saturating): increments while din_s=0; cleared while din_s=1.
- States: SYNC, RX.
- SYNC:
  - Ignores all pulses; no valid, no bit_error.
  - Moves to RX on the cycle low_cnt reaches T_RESET.
  - bit_cnt=0, led_idx=0 on entry.
- RX, on falling edge with h = high_cnt (count at that edge):
  - h < T_MIN: pulse ignored; bit_error pulse.
  - T_MIN <= h <= T_MAX: shift bit (h > T_THRESH) into shift register; bit_cnt++.
  - h > T_MAX: bit_error pulse; discard partial word; go to SYNC.
- Word complete (bit_cnt reaches 24):
  - If led_idx < NUM_LEDS: rgb_data = shift register, led_num = led_idx, valid pulse, led_idx++.
  - Otherwise the word is dropped silently.
  - bit_cnt returns to 0.
- Latency: valid rises after the 3rd rising clk edge following the first edge that samples din=0 on the 24th bit. rgb_data/led_num hold until the next valid or reset.
- Frame end, in RX when low_cnt reaches exactly T_RESET:
  - frame_done pulses if any bit was received since the last frame end.
  - If bit_cnt != 0, bit_error pulses in the same cycle and the partial word is discarded.
  - led_idx=0, bit_cnt=0; remain in RX.
  - Saturated low_cnt produces no repeated pulses.
- busy: deasserts in the same cycle frame_done pulses.
- Simultaneous events: valid and bit_error never coincide. valid and frame_done cannot coincide, since frame end requires T_RESET low cycles after the last edge.

Test Plan:
1. Reset, din low 650 clk, then 24 bits of 0xA5C30F (1 = 10 high/5 low, 0 = 5 high/10 low) -> single valid pulse, rgb_data=0xA5C30F, led_num=0, bit_error never high.
2. Frame of 9 words 0x000001..0x000009 then 650 low -> valid for led_num 0..7 with matching data; 9th word dropped; exactly one frame_done when low_cnt=600; busy low afterwards.
3. Bits driven immediately after reset release with no preceding gap -> no valid or bit_error until a ≥600-cycle low occurs; the following frame decodes from led_num 0.
4. 1-cycle high glitch inserted in the low phase of bit 5 -> one bit_error pulse; word still decodes to the transmitted value. Separately, a 20-cycle high pulse mid-word -> bit_error, no valid for the rest of the frame; next frame after 600 low is correct.
5. Frame ends after 12 bits of a word -> frame_done and bit_error in the same cycle, no valid; next word reports led_num=0.
6. reset asserted for 1 cycle during bit 10 of word 2 -> all outputs 0 next cycle; subsequent bits ignored until a 600-cycle low; then normal decode.
